// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Byte offset bits inside one 64-bit word.
    localparam int WORD_OFFSET = 3;

    function automatic logic addr_misaligned(input logic [WORD_OFFSET-1:0] lo);
        return lo != '0;
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - two-input round-robin grant with last_grant history
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Bit 0 is the core, bit 1 the debug port; on a tie the port that did not win last time goes.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == REQ_DBG) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update && (grant != 2'b00)) begin
            last_grant_d = grant[REQ_DBG];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter for the single-port data memory (option: DMEM_ARB_MISALIGN_CHECK_EN)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 256,
    localparam int MW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    output logic                  core_rsp_err,

    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_we,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic                  dbg_rsp_err,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state_q, state_d;
    logic                  gid_q, gid_d;
    logic                  we_q, we_d;
    logic [MW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic                  core_rsp_valid_q, core_rsp_valid_d;
    logic                  dbg_rsp_valid_q, dbg_rsp_valid_d;

    logic [1:0]            grant;
    logic                  rr_update;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_misaligned;
    logic                  unused_addr_bits;

    dmem_arb_rr u_rr (
        .clk    (clk),
        .reset  (reset),
        .valid  ({dbg_req_valid, core_req_valid}),
        .update (rr_update),
        .grant  (grant)
    );

    assign sel_we    = grant[REQ_DBG] ? dbg_req_we    : core_req_we;
    assign sel_addr  = grant[REQ_DBG] ? dbg_req_addr  : core_req_addr;
    assign sel_wdata = grant[REQ_DBG] ? dbg_req_wdata : core_req_wdata;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    assign sel_misaligned = addr_misaligned(sel_addr[WORD_OFFSET-1:0]);
`else
    assign sel_misaligned = 1'b0;
`endif

    // Upper address bits wrap away and, without the check, so do the byte-offset bits.
    assign unused_addr_bits = ^{core_req_addr, dbg_req_addr};

    always_comb begin
        state_d          = state_q;
        gid_d            = gid_q;
        we_d             = we_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        err_d            = err_q;
        mem_en_d         = 1'b0;
        mem_we_d         = 1'b0;
        core_rsp_valid_d = 1'b0;
        dbg_rsp_valid_d  = 1'b0;
        rr_update        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    rr_update = 1'b1;
                    gid_d     = grant[REQ_DBG];
                    we_d      = sel_we;
                    addr_d    = sel_addr[WORD_OFFSET +: MW];
                    wdata_d   = sel_wdata;
                    err_d     = sel_misaligned;
                    // A flagged access never touches memory; it only reports the error.
                    mem_en_d  = !sel_misaligned;
                    mem_we_d  = sel_we && !sel_misaligned;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_rsp_valid_d = (gid_q == REQ_CORE);
                dbg_rsp_valid_d  = (gid_q == REQ_DBG);
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            gid_q            <= REQ_CORE;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            err_q            <= 1'b0;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            dbg_rsp_valid_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            gid_q            <= gid_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            err_q            <= err_d;
            mem_en_q         <= mem_en_d;
            mem_we_q         <= mem_we_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            dbg_rsp_valid_q  <= dbg_rsp_valid_d;
        end
    end

    // Ready is combinational so a requester is accepted in the same cycle it is granted.
    assign core_req_ready = (state_q == ST_IDLE) && grant[REQ_CORE] && !reset;
    assign dbg_req_ready  = (state_q == ST_IDLE) && grant[REQ_DBG]  && !reset;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Read data arrives from the memory during RESP, so it is forwarded rather than registered.
    assign core_rsp_valid = core_rsp_valid_q;
    assign dbg_rsp_valid  = dbg_rsp_valid_q;
    assign core_rsp_rdata = (core_rsp_valid_q && !we_q && !err_q) ? mem_rdata : '0;
    assign dbg_rsp_rdata  = (dbg_rsp_valid_q  && !we_q && !err_q) ? mem_rdata : '0;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    assign core_rsp_err = core_rsp_valid_q && err_q;
    assign dbg_rsp_err  = dbg_rsp_valid_q  && err_q;
`else
    assign core_rsp_err = 1'b0;
    assign dbg_rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (honours DMEM_ARB_MISALIGN_CHECK_EN)
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req_valid = 1'b0, core_req_we = 1'b0;
    logic [63:0] core_req_addr = '0, core_req_wdata = '0;
    logic        dbg_req_valid = 1'b0, dbg_req_we = 1'b0;
    logic [63:0] dbg_req_addr = '0, dbg_req_wdata = '0;
    logic        core_req_ready, dbg_req_ready;
    logic        core_rsp_valid, dbg_rsp_valid, core_rsp_err, dbg_rsp_err;
    logic [63:0] core_rsp_rdata, dbg_rsp_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    logic [63:0] mem [256];
    logic [63:0] exp_mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [63:0] poke_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
        .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read single-port memory, with a back door for preloading.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  exp_maddr;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    function automatic logic [63:0] pattern(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h0101_0101};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [63:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = 8'(a); poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic set_port(input bit p, input bit v, input bit we,
                            input logic [63:0] a, input logic [63:0] d);
        if (p) begin
            dbg_req_valid = v; dbg_req_we = we; dbg_req_addr = a; dbg_req_wdata = d;
        end else begin
            core_req_valid = v; core_req_we = we; core_req_addr = a; core_req_wdata = d;
        end
    endtask

    // One complete access on port p, checking accept, issue and response cycles.
    task automatic access(input vec_t v);
        int cyc = 0;
        @(negedge clk);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        #1;
        while (!(v.port ? dbg_req_ready : core_req_ready) && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("accept", v.port ? dbg_req_ready : core_req_ready, 1);
        @(posedge clk); #1;
        set_port(v.port, 1'b0, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk("issue_mem_en", mem_en, !v.exp_err);
        if (!v.exp_err) begin
            chk("issue_mem_addr", mem_addr, v.exp_maddr);
            chk("issue_mem_we", mem_we, v.we);
            if (v.we) chk("issue_mem_wdata", mem_wdata, v.wdata);
        end
        chk("issue_no_rsp", core_rsp_valid | dbg_rsp_valid, 0);
        @(negedge clk);
        chk("rsp_valid", v.port ? dbg_rsp_valid : core_rsp_valid, 1);
        chk("rsp_other_quiet", v.port ? core_rsp_valid : dbg_rsp_valid, 0);
        chk("rsp_rdata", v.port ? dbg_rsp_rdata : core_rsp_rdata, v.exp_rdata);
        chk("rsp_err", v.port ? dbg_rsp_err : core_rsp_err, v.exp_err);
        chk("resp_mem_en_low", mem_en, 0);
    endtask

    initial begin
        bit          pend [2];
        bit          rwe [2];
        logic [63:0] raddr [2];
        logic [63:0] rwd [2];
        int          last_m;

        for (int i = 0; i < 256; i++) poke(i, pattern(i));
        poke(32, 64'h1234_5678_90AB_CDEF);

        @(negedge clk);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rsp", {core_rsp_valid, dbg_rsp_valid, core_rsp_err, dbg_rsp_err}, 0);
        chk("reset_ready", {core_req_ready, dbg_req_ready}, 0);
        reset = 1'b0;

        vecs[0] = '{0, 0, 64'h100, 0, 8'd32, 64'h1234_5678_90AB_CDEF, 0};
        vecs[1] = '{1, 1, 64'h200, 64'hB, 8'd64, 0, 0};
        vecs[2] = '{0, 0, 64'h200, 0, 8'd64, 64'hB, 0};
        vecs[3] = CHECK_EN ? '{0, 0, 64'h104, 0, 8'd32, 64'h0, 1}
                           : '{0, 0, 64'h104, 0, 8'd32, 64'h1234_5678_90AB_CDEF, 0};
        vecs[4] = '{0, 0, 64'h800, 0, 8'd0, pattern(0), 0};
        vecs[5] = '{1, 0, 64'hFFFF_0000_0000_09F8, 0, 8'd63, pattern(63), 0};
        vecs[6] = CHECK_EN ? '{1, 1, 64'h201, 64'h77, 8'd64, 0, 1}
                           : '{1, 1, 64'h201, 64'h77, 8'd64, 0, 0};
        vecs[7] = '{0, 0, 64'h200, 0, 8'd64, CHECK_EN ? 64'hB : 64'h77, 0};

        for (int i = 0; i < 8; i++) begin
            access(vecs[i]);
            if (vecs[i].we && !vecs[i].exp_err) exp_mem[vecs[i].exp_maddr] = vecs[i].wdata;
        end
        chk("mem64_after_table", mem[64], CHECK_EN ? 64'hB : 64'h77);

        // Reset while a store is in ISSUE: no write, no response.
        poke(64, 64'h55);
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, 64'h200, 64'hB);
        #1;
        chk("rst_seq_accept", dbg_req_ready, 1);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b1, 64'h200, 64'hB);
        @(negedge clk);
        chk("rst_seq_issue", mem_en, 1);
        #1 reset = 1'b1;
        #1 chk("rst_mem_en_drop", mem_en, 0);
        @(negedge clk);
        chk("rst_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        reset = 1'b0;
        chk("rst_mem64_kept", mem[64], 64'h55);
        access('{0, 0, 64'h100, 0, 8'd32, 64'h1234_5678_90AB_CDEF, 0});

        // Both requesters hold valid from reset: alternate grants every 3 cycles.
        @(negedge clk);
        reset = 1'b1;
        set_port(0, 1'b1, 1'b0, 64'h100, 0);
        set_port(1, 1'b1, 1'b0, 64'h208, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("rr_core_ready_c%0d", c), core_req_ready, (c % 6) == 0);
            chk($sformatf("rr_dbg_ready_c%0d", c), dbg_req_ready, (c % 6) == 3);
            chk("rr_rsp_exclusive", core_rsp_valid & dbg_rsp_valid, 0);
            if (c < 12) begin
                @(negedge clk); #1;
            end
        end
        set_port(0, 1'b0, 1'b0, 0, 0);
        set_port(1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);

        // Random traffic against a request-level model of grant order and memory.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_m = 1;
        pend[0] = 0; pend[1] = 0;
        for (int s = 0; s < 150; s++) begin
            int          win;
            logic [7:0]  ma;
            bit          mis;
            logic [63:0] erd;
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]  = 1;
                    rwe[p]   = $urandom_range(0, 1) == 1;
                    raddr[p] = {$urandom, $urandom};
                    if ($urandom_range(0, 7) != 0) raddr[p][2:0] = 3'b000;
                    rwd[p]   = {$urandom, $urandom};
                end
                set_port(p[0], pend[p], rwe[p], raddr[p], rwd[p]);
            end
            #1;
            if (pend[0] && pend[1]) win = (last_m == 1) ? 0 : 1;
            else if (pend[0])       win = 0;
            else if (pend[1])       win = 1;
            else                    win = -1;
            chk("rnd_core_ready", core_req_ready, win == 0);
            chk("rnd_dbg_ready", dbg_req_ready, win == 1);
            if (win >= 0) begin
                last_m = win;
                ma  = raddr[win][10:3];
                mis = CHECK_EN && (raddr[win][2:0] != 0);
                erd = (rwe[win] || mis) ? 64'h0 : exp_mem[ma];
                @(posedge clk); #1;
                pend[win] = 0;
                set_port(win[0], 1'b0, rwe[win], raddr[win], rwd[win]);
                @(negedge clk);
                chk("rnd_mem_en", mem_en, !mis);
                if (!mis) begin
                    chk("rnd_mem_addr", mem_addr, ma);
                    chk("rnd_mem_we", mem_we, rwe[win]);
                end
                chk("rnd_busy_no_ready", core_req_ready | dbg_req_ready, 0);
                @(negedge clk);
                chk("rnd_rsp_valid", {dbg_rsp_valid, core_rsp_valid}, (win == 1) ? 2'b10 : 2'b01);
                chk("rnd_rsp_rdata", (win == 1) ? dbg_rsp_rdata : core_rsp_rdata, erd);
                chk("rnd_rsp_err", (win == 1) ? dbg_rsp_err : core_rsp_err, mis);
                if (rwe[win] && !mis) exp_mem[ma] = rwd[win];
            end
        end
        set_port(0, 1'b0, 1'b0, 0, 0);
        set_port(1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("final_mem_%0d", i), mem[i], exp_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 64-bit data memory between two requesters: the processor's load/store port (core) and a debug/loader port (dbg). The processor reaches data memory through this block. Each requester has a valid/ready request channel and a one-cycle response pulse. Arbitration is round-robin. Each memory access takes a fixed three-state sequence, giving one access every three cycles.

## Interface
- `ADDR_WIDTH`, 64: byte-address width of requester addresses.
- `DATA_WIDTH`, 64: data word width.
- `MEM_DEPTH`, 256: memory depth in words. `MW = $clog2(MEM_DEPTH)`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `core_req_valid` / `dbg_req_valid`  in  1  request present.
- `core_req_ready` / `dbg_req_ready`  out  1  request accepted this cycle.
- `core_req_we` / `dbg_req_we`  in  1  1 = store, 0 = load.
- `core_req_addr` / `dbg_req_addr`  in  ADDR_WIDTH  byte address.
- `core_req_wdata` / `dbg_req_wdata`  in  DATA_WIDTH  store data.
- `core_rsp_valid` / `dbg_rsp_valid`  out  1  one-cycle completion pulse.
- `core_rsp_rdata` / `dbg_rsp_rdata`  out  DATA_WIDTH  load data. 0 for stores.
- `core_rsp_err` / `dbg_rsp_err`  out  1  misaligned-access error. Tied 0 without the macro.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  MW  word index.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after `mem_en` (synchronous read).

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE:**
  - If any request is valid, grant one requester and go to ISSUE.
  - Latch the winner's `we`, `addr` and `wdata`, and the grant id.
- **ISSUE:**
  - Drive `mem_en = 1`, `mem_we` and `mem_addr`/`mem_wdata` from the latched fields.
  - Go to RESP.
- **RESP:**
  - Pulse the granted requester's `rsp_valid`.
  - `rsp_rdata` = `mem_rdata` for loads, 0 for stores.
  - Go to IDLE.
- **Ready rule:**
  - `req_ready` is asserted only in IDLE, only for the granted requester, and only while its `req_valid` is high.
  - `req_ready` depends combinationally on both `req_valid` inputs.
  - Requesters must hold their request fields stable until ready.
- **Round-robin:**
  - A `last_grant` register (reset value = dbg) is updated on every grant.
  - On a tie, the requester not in `last_grant` wins. The core therefore wins the first tie after reset.
  - With only one request valid, that requester is granted regardless of `last_grant`.
- **Responses:** there is no backpressure. The requester must consume the `rsp_valid` pulse in its cycle.
- **Address mapping:**
  - `mem_addr = addr[MW+2:3]`.
  - Bits above `MW+2` are ignored, so addresses wrap modulo `MEM_DEPTH*8`.
  - Bits [2:0] are ignored unless the macro is defined.
- **Reset behaviour:**
  - All outputs reset to 0, state to IDLE, `last_grant` to dbg, latched fields to 0.
  - Reset acts immediately and asynchronously.
  - Reset asserted while in ISSUE forces `mem_en` low before the edge, so no write commits.
  - A request whose access is cut off by reset gets no response and must be re-issued.

## Timing
- Latency: request accepted at edge T; `mem_en` high in cycle T+1; `rsp_valid` high in cycle T+2.
- Throughput: at most one access per 3 cycles. Back-to-back requests are accepted at T, T+3, T+6, …
- `rsp_valid` is never high on both requesters in the same cycle.
- `mem_en` is never high outside ISSUE.

## Configuration
- Macro: `DMEM_ARB_MISALIGN_CHECK_EN`.
- **Defined:**
  - A request with `addr[2:0] != 0` is still accepted normally.
  - In ISSUE, `mem_en` stays 0.
  - In RESP, `rsp_err = 1` and `rsp_rdata = 0`.
- **Undefined:** the low address bits are silently dropped and `rsp_err` outputs are constant 0.

## Structure
- **Package `dmem_arb_pkg`:**
  - FSM state enum (`ST_IDLE`, `ST_ISSUE`, `ST_RESP`).
  - Requester id constants (`REQ_CORE = 0`, `REQ_DBG = 1`).
  - `WORD_OFFSET = 3`.
- **Sub-module `dmem_arb_rr`:**
  - Two-input round-robin grant logic plus the `last_grant` register.
  - Inputs: valids and an update strobe. Output: one-hot grant.

## Test plan
- Preload `mem[32] = 0x1234567890ABCDEF`; core loads 0x100 → `core_rsp_valid` 2 cycles after accept with that data; `dbg_rsp_valid` stays 0.
- Dbg stores 0xB to 0x200, then core loads 0x200 → `mem[64] = 0xB` and `core_rsp_rdata = 0xB`; the store response has `rdata = 0`.
- Both valid continuously from reset → grant order core, dbg, core, dbg; accepts spaced exactly 3 cycles apart.
- Assert reset during ISSUE of a dbg store of 0xB to 0x200 → `mem_en` drops immediately, `mem[64]` unchanged, no response; after release, a core load of 0x100 completes normally.
- Load from 0x104:
  - With `DMEM_ARB_MISALIGN_CHECK_EN` → `rsp_err = 1`, `rdata = 0`, no `mem_en`.
  - Without the macro → returns `mem[32]`.
- Load from 0x800 with `MEM_DEPTH = 256` → `mem_addr = 0` (wrap).
